// File: rtl/rom_bank_loader.sv
// ROM download front end plus bank mapper: stores download words to memory through a
// toggle handshake, tracks the image size/mirroring mask and translates CPU addresses.
module rom_bank_loader #(
    parameter int BANKS = 8,
    parameter int BW    = 6,
    parameter int SHIFT = 19,
    parameter int AW    = 23,
    parameter int SWAP  = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       dl_active,
    input  logic                       dl_wr,
    input  logic [24:0]                dl_addr,
    input  logic [15:0]                dl_data,
    output logic                       dl_wait,
    output logic [24:0]                wr_addr,
    output logic [15:0]                wr_data,
    output logic                       wr_req,
    input  logic                       wr_ack,
    input  logic                       map_we,
    input  logic [$clog2(BANKS)-1:0]   map_a,
    input  logic [BW-1:0]              map_d,
    input  logic [AW-1:0]              cpu_addr,
    output logic [24:0]                rd_addr,
    output logic [24:0]                rom_size,
    output logic [24:0]                rom_mask,
    output logic                       sram_en
);

    localparam int MW = BW + SHIFT;

    logic              dl_active_q, dl_active_d;
    logic              dl_wait_q, dl_wait_d;
    logic              ack_done_q, ack_done_d;
    logic              wr_req_q, wr_req_d;
    logic [24:0]       wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [24:0]       rom_size_q, rom_size_d;
    logic [24:0]       rom_mask_n_q, rom_mask_n_d;
    logic [24:0]       rd_addr_q, rd_addr_d;
    logic [BW-1:0]     bank_q [BANKS];
    logic [BW-1:0]     bank_d [BANKS];
    logic              use_map_q, use_map_d;
    logic              sram_en_q, sram_en_d;

    logic              dl_start, dl_stop, dl_accept;
    logic [24:0]       next_size;
    logic [MW-1:0]     mapped_addr;
    logic [24:0]       base_addr;

    // Smallest 2^n - 1 covering size; a zero size yields all ones.
    function automatic logic [24:0] size_to_mask(input logic [24:0] size);
        logic [24:0] m;
        m = size - 25'd1;
        for (int i = 23; i >= 0; i--) begin
            m[i] = m[i] | m[i + 1];
        end
        return m;
    endfunction

    always_comb begin
        dl_active_d  = dl_active;
        dl_wait_d    = dl_wait_q;
        ack_done_d   = 1'b0;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rom_size_d   = rom_size_q;
        rom_mask_n_d = rom_mask_n_q;
        bank_d       = bank_q;
        use_map_d    = use_map_q;
        sram_en_d    = sram_en_q;

        dl_start  = dl_active && !dl_active_q;
        dl_stop   = !dl_active && dl_active_q;
        dl_accept = dl_wr && !dl_wait_q && !reset;
        next_size = dl_addr + 25'd2;

        if (dl_start) begin
            wr_req_d   = wr_ack;
            rom_size_d = '0;
        end

        // The ack is observed on one edge and dl_wait drops on the following one.
        ack_done_d = dl_wait_q && !ack_done_q && (wr_req_q == wr_ack);
        if (ack_done_q) begin
            dl_wait_d = 1'b0;
        end

        if (dl_accept) begin
            wr_addr_d = dl_addr;
            wr_data_d = (SWAP != 0) ? {dl_data[7:0], dl_data[15:8]} : dl_data;
            wr_req_d  = !wr_req_d;
            dl_wait_d = 1'b1;
            if (next_size > rom_size_d) begin
                rom_size_d = next_size;
            end
        end

        // Mask is stored inverted so the zero power-up state reads as all ones.
        if (dl_active) begin
            rom_mask_n_d = '0;
        end else if (dl_stop) begin
            rom_mask_n_d = ~size_to_mask(rom_size_q);
        end

        mapped_addr = {bank_q[cpu_addr[AW-1:SHIFT]], cpu_addr[SHIFT-1:0]};
        base_addr   = use_map_q ? 25'(mapped_addr) : 25'(cpu_addr);
        rd_addr_d   = base_addr & ~rom_mask_n_q;

        if (map_we) begin
            if (map_a != '0) begin
                bank_d[map_a] = map_d;
                use_map_d     = 1'b1;
            end else begin
                sram_en_d = map_d[0];
            end
        end

        if (reset) begin
            for (int i = 0; i < BANKS; i++) begin
                bank_d[i] = BW'(i);
            end
            use_map_d  = 1'b0;
            sram_en_d  = 1'b0;
            dl_wait_d  = 1'b0;
            ack_done_d = 1'b0;
            rd_addr_d  = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        dl_active_q  <= dl_active_d;
        dl_wait_q    <= dl_wait_d;
        ack_done_q   <= ack_done_d;
        wr_req_q     <= wr_req_d;
        wr_addr_q    <= wr_addr_d;
        wr_data_q    <= wr_data_d;
        rom_size_q   <= rom_size_d;
        rom_mask_n_q <= rom_mask_n_d;
        rd_addr_q    <= rd_addr_d;
        bank_q       <= bank_d;
        use_map_q    <= use_map_d;
        sram_en_q    <= sram_en_d;
    end

    assign dl_wait  = dl_wait_q;
    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rom_size = rom_size_q;
    assign rom_mask = ~rom_mask_n_q;
    assign rd_addr  = rd_addr_q;
    assign sram_en  = sram_en_q;

endmodule

// File: tb/tb_rom_bank_loader.sv
// Bench for rom_bank_loader: directed and randomized downloads and mapper traffic,
// checked against an arithmetic model of image size, mask and address translation.
module tb_rom_bank_loader;

    logic        clk_sys;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic        wr_ack;
    logic        map_we;
    logic [2:0]  map_a;
    logic [5:0]  map_d;
    logic [22:0] cpu_addr;

    logic        dl_wait, wr_req, sram_en;
    logic [24:0] wr_addr, rd_addr, rom_size, rom_mask;
    logic [15:0] wr_data;

    logic        dl_wait_n, wr_req_n, sram_en_n;
    logic [24:0] wr_addr_n, rd_addr_n, rom_size_n, rom_mask_n;
    logic [15:0] wr_data_n;

    int total = 0;
    int bad   = 0;

    int unsigned m_map [8];
    bit          m_use;
    bit          m_sram;
    bit          m_req;
    longint      m_size;
    logic [24:0] m_mask;

    rom_bank_loader #(.SWAP(1)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack), .map_we(map_we),
        .map_a(map_a), .map_d(map_d), .cpu_addr(cpu_addr), .rd_addr(rd_addr),
        .rom_size(rom_size), .rom_mask(rom_mask), .sram_en(sram_en)
    );

    rom_bank_loader #(.SWAP(0)) u_nosw (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait_n), .wr_addr(wr_addr_n),
        .wr_data(wr_data_n), .wr_req(wr_req_n), .wr_ack(wr_ack), .map_we(map_we),
        .map_a(map_a), .map_d(map_d), .cpu_addr(cpu_addr), .rd_addr(rd_addr_n),
        .rom_size(rom_size_n), .rom_mask(rom_mask_n), .sram_en(sram_en_n)
    );

    // Free-running system clock.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Mask is the smallest power of two covering the image, minus one.
    function automatic logic [24:0] model_mask(input longint size);
        longint p;
        if (size == 0) return 25'h1FF_FFFF;
        p = 1;
        while (p < size) p = p * 2;
        return 25'(p - 1);
    endfunction

    function automatic logic [24:0] model_rd(input logic [22:0] cpu);
        longint bank, off, base;
        bank = longint'(cpu) / (longint'(1) << 19);
        off  = longint'(cpu) % (longint'(1) << 19);
        base = m_use ? (longint'(m_map[bank]) * (longint'(1) << 19) + off) : longint'(cpu);
        return 25'(base) & m_mask;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_map[i] = i;
        m_use  = 1'b0;
        m_sram = 1'b0;
    endtask

    task automatic startDownload();
        dl_active = 1'b1;
        step();
        m_size = 0;
        m_mask = 25'h1FF_FFFF;
        m_req  = wr_ack;
        checkOutput("start_size", rom_size, 32'd0);
        checkOutput("start_mask", rom_mask, m_mask);
        checkOutput("start_req", wr_req, m_req);
    endtask

    task automatic endDownload();
        dl_active = 1'b0;
        step();
        m_mask = model_mask(m_size);
        checkOutput("end_size", rom_size, 32'(m_size));
        checkOutput("end_mask", rom_mask, m_mask);
    endtask

    // One accepted write, memory ack returned 'delay' cycles after the request.
    task automatic applyStimulus(input logic [24:0] addr, input logic [15:0] data, input int delay);
        int highs;
        dl_addr = addr;
        dl_data = data;
        dl_wr   = 1'b1;
        step();
        dl_wr = 1'b0;
        m_req = !m_req;
        if (longint'(addr) + 2 > m_size) m_size = longint'(addr) + 2;
        checkOutput("wr_req_toggle", wr_req, m_req);
        checkOutput("wr_addr", wr_addr, addr);
        checkOutput("wr_data_swap", wr_data, {data[7:0], data[15:8]});
        checkOutput("wr_data_noswap", wr_data_n, data);
        checkOutput("dl_wait_set", dl_wait, 32'd1);
        if (delay == 0) wr_ack = m_req;
        highs = 1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) begin
                dl_addr = addr ^ 25'h100;
                dl_wr   = 1'b1;
            end
            step();
            dl_wr = 1'b0;
            if (c == delay) wr_ack = m_req;
            if (!dl_wait) break;
            highs++;
        end
        checkOutput("dl_wait_cycles", highs, delay + 2);
        checkOutput("ignored_wr_addr", wr_addr, addr);
        checkOutput("ignored_wr_req", wr_req, m_req);
    endtask

    initial begin
        logic [24:0] a;
        logic [22:0] ca;
        logic [24:0] exp_rd;
        bit          do_we;

        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        wr_ack = 1'b0; map_we = 1'b0; map_a = '0; map_d = '0; cpu_addr = '0;
        model_reset();
        m_size = 0; m_mask = 25'h1FF_FFFF; m_req = 1'b0;

        $display("[TB] reset state");
        repeat (3) step();
        checkOutput("rst_dl_wait", dl_wait, 32'd0);
        checkOutput("rst_sram_en", sram_en, 32'd0);
        checkOutput("rst_rd_addr", rd_addr, 32'd0);
        checkOutput("rst_wr_req", wr_req, 32'd0);
        checkOutput("rst_rom_size", rom_size, 32'd0);
        checkOutput("rst_rom_mask", rom_mask, 32'h1FF_FFFF);
        reset = 1'b0;

        cpu_addr = 23'($urandom);
        step();
        checkOutput("rd_unmapped", rd_addr, model_rd(cpu_addr));

        $display("[TB] three-word download");
        startDownload();
        applyStimulus(25'd0, 16'h1234, 3);
        applyStimulus(25'd2, 16'($urandom), 3);
        applyStimulus(25'd4, 16'($urandom), 3);
        checkOutput("mask_while_active", rom_mask, 32'h1FF_FFFF);
        endDownload();
        checkOutput("size_6", rom_size, 32'd6);
        checkOutput("mask_7", rom_mask, 32'h7);
        checkOutput("nosw_req", wr_req_n, m_req);
        checkOutput("nosw_addr", wr_addr_n, 32'd4);
        checkOutput("nosw_wait", dl_wait_n, 32'd0);
        checkOutput("nosw_size", rom_size_n, 32'd6);
        checkOutput("nosw_mask", rom_mask_n, 32'h7);

        $display("[TB] random download");
        startDownload();
        for (int i = 0; i < 5; i++) begin
            a = 25'($urandom_range(0, 32'h3FFFF) * 2);
            applyStimulus(a, 16'($urandom), int'($urandom_range(0, 4)));
        end
        endDownload();

        $display("[TB] large image and bank mapping");
        startDownload();
        applyStimulus(25'h2F_FFFE, 16'($urandom), 1);
        endDownload();
        checkOutput("mask_3mb", rom_mask, 32'h3F_FFFF);
        map_we = 1'b1; map_a = 3'd7; map_d = 6'h0A; cpu_addr = 23'h3A_0010;
        exp_rd = model_rd(cpu_addr);
        step();
        map_we = 1'b0;
        checkOutput("rd_old_map", rd_addr, exp_rd);
        m_map[7] = 32'h0A; m_use = 1'b1;
        step();
        checkOutput("rd_new_map", rd_addr, model_rd(cpu_addr));
        checkOutput("rd_120010", rd_addr, 32'h12_0010);

        $display("[TB] reset with coincident map write");
        reset = 1'b1; map_we = 1'b1; map_a = 3'd3; map_d = 6'h2A;
        step();
        reset = 1'b0; map_we = 1'b0;
        model_reset();
        checkOutput("rst_map_rd", rd_addr, 32'd0);
        checkOutput("rst_map_sram", sram_en, 32'd0);
        map_we = 1'b1; map_a = 3'd0; map_d = 6'h01;
        cpu_addr = 23'($urandom_range(0, 32'h7FFFF));
        step();
        map_we = 1'b0; m_sram = 1'b1;
        checkOutput("sram_set", sram_en, 32'd1);
        step();
        checkOutput("rd_bank0_nomap", rd_addr, model_rd(cpu_addr));
        cpu_addr = 23'h1C_0123;
        step();
        checkOutput("rd_bank3_nomap", rd_addr, model_rd(cpu_addr));
        map_we = 1'b1; map_a = 3'd1; map_d = 6'h01;
        step();
        map_we = 1'b0; m_use = 1'b1;
        step();
        checkOutput("rd_bank3_identity", rd_addr, model_rd(cpu_addr));
        cpu_addr = 23'h3A_0010;
        step();
        checkOutput("rd_bank7_identity", rd_addr, model_rd(cpu_addr));

        $display("[TB] random mapper traffic");
        for (int i = 0; i < 40; i++) begin
            do_we    = 1'($urandom);
            map_we   = do_we;
            map_a    = 3'($urandom);
            map_d    = 6'($urandom);
            cpu_addr = 23'($urandom);
            exp_rd   = model_rd(cpu_addr);
            step();
            if (do_we) begin
                if (map_a != 3'd0) begin
                    m_map[map_a] = map_d;
                    m_use = 1'b1;
                end else begin
                    m_sram = map_d[0];
                end
            end
            map_we = 1'b0;
            checkOutput("rand_rd", rd_addr, exp_rd);
            checkOutput("rand_sram", sram_en, m_sram);
        end

        $display("[TB] reset during pending write");
        startDownload();
        dl_addr = 25'h40; dl_data = 16'($urandom); dl_wr = 1'b1;
        step();
        dl_wr = 1'b0; m_req = !m_req; m_size = 32'h42;
        checkOutput("pend_req", wr_req, m_req);
        step();
        checkOutput("pend_wait", dl_wait, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        checkOutput("pend_rst_wait", dl_wait, 32'd0);
        checkOutput("pend_rst_req", wr_req, m_req);
        checkOutput("pend_rst_rd", rd_addr, 32'd0);
        wr_ack = m_req;
        repeat (3) step();
        checkOutput("late_ack_req", wr_req, m_req);
        checkOutput("late_ack_wait", dl_wait, 32'd0);
        endDownload();
        checkOutput("final_sram_n", sram_en_n, 32'd0);
        cpu_addr = 23'($urandom);
        step();
        checkOutput("final_rd", rd_addr, model_rd(cpu_addr));
        checkOutput("final_rd_n", rd_addr_n, model_rd(cpu_addr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
